// File: rtl/cpu_pkg.sv
// Shared CPU types for the memory arbiter: FSM state and grant owner encodings.
// Latency: n/a (types and constant helpers only).
// Backpressure: n/a.
package cpu_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT,
        ARB_DONE
    } arb_state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } arb_grant_t;

    // Width needed to hold values 0..lat inclusive for the latency down-counter.
    function automatic int lat_cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and memory port seen by mem_arbiter.
// Latency: n/a (wiring only).
// Backpressure: requesters hold *_req and their address stable until *_valid.
//
// slave  : arbiter view (takes requests and mem_rdata, drives responses and memory strobe)
// master : CPU + memory view (drives requests and mem_rdata, observes the rest)
interface mem_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);

    // instruction-fetch port
    logic                     if_req;
    logic [ADDRESS_WIDTH-1:0] if_addr;
    logic                     if_kill;
    logic [DATA_WIDTH-1:0]    if_rdata;
    logic                     if_valid;

    // load/store port
    logic                     d_req;
    logic                     d_we;
    logic [ADDRESS_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0]    d_wdata;
    logic [DATA_WIDTH-1:0]    d_rdata;
    logic                     d_valid;

    // single-port memory
    logic                     mem_en;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        output if_rdata, if_valid,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_valid,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr, if_kill,
        input  if_rdata, if_valid,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_valid,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/lat_counter.sv
// Loadable down-counter that times the fixed memory latency.
// Latency: load takes effect next cycle; last is combinational from the count.
// Backpressure: none; dec is ignored once the count reaches zero.
//
// Ports: clk, rst (async active-low), load (preset to MEM_LATENCY-1),
//        dec (count down by one), last (count equals 1).
module lat_counter
    import cpu_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    localparam int CW = lat_cnt_width(MEM_LATENCY);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(MEM_LATENCY - 1);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // The arbiter leaves WAIT in the cycle the count sits at 1, so DONE lands
    // exactly MEM_LATENCY cycles after the strobe.
    assign last = (cnt == CW'(1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and load/store.
// Latency: request seen in IDLE at N -> mem_en at N+1, valid at N+1+MEM_LATENCY, IDLE at N+2+MEM_LATENCY.
// Backpressure: a requester stalls (req & ~valid) until its one-cycle valid pulse; contention alternates.
//
// Ports: clk (rising edge), rst (async active-low), bus (mem_arbiter_if.slave: fetch port,
//        data port and memory port). MEM_LATENCY must be 1 or greater.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_LATENCY   = 2
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    arb_state_t               state;
    arb_grant_t               owner;
    arb_grant_t               last_grant;
    logic                     kill_pend;

    // memory-side registers, driven straight onto the memory port
    logic                     en_q;
    logic                     we_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic                     grant_any;
    logic                     grant_data;
    logic                     fetch_kill;
    logic                     in_done;
    logic                     cnt_load;
    logic                     cnt_dec;
    logic                     cnt_last;

    // Data wins unless it was also the previous winner and fetch is waiting,
    // which gives strict alternation under sustained contention.
    always_comb begin
        grant_any  = bus.d_req || bus.if_req;
        grant_data = bus.d_req && (!bus.if_req || (last_grant != GNT_DATA));
    end

    // Kill only matters while a fetch owns the memory.
    assign fetch_kill = bus.if_kill && (owner == GNT_FETCH);

    assign cnt_load = (state == ARB_ISSUE);
    assign cnt_dec  = (state == ARB_WAIT);

    lat_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .last (cnt_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ARB_IDLE;
            owner      <= GNT_FETCH;
            last_grant <= GNT_FETCH;
            kill_pend  <= 1'b0;
            en_q       <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (grant_any) begin
                        // Strobe and address are registered here so the
                        // memory port never sees a combinational path from req.
                        state <= ARB_ISSUE;
                        en_q  <= 1'b1;
                        if (grant_data) begin
                            owner      <= GNT_DATA;
                            last_grant <= GNT_DATA;
                            addr_q     <= bus.d_addr;
                            wdata_q    <= bus.d_wdata;
                            we_q       <= bus.d_we;
                        end else begin
                            // Fetch never writes; wdata keeps its last value.
                            owner      <= GNT_FETCH;
                            last_grant <= GNT_FETCH;
                            addr_q     <= bus.if_addr;
                            we_q       <= 1'b0;
                        end
                    end
                end

                ARB_ISSUE: begin
                    en_q  <= 1'b0;
                    we_q  <= 1'b0;
                    state <= (MEM_LATENCY == 1) ? ARB_DONE : ARB_WAIT;
                    if (fetch_kill) begin
                        kill_pend <= 1'b1;
                    end
                end

                ARB_WAIT: begin
                    if (cnt_last) begin
                        state <= ARB_DONE;
                    end
                    if (fetch_kill) begin
                        kill_pend <= 1'b1;
                    end
                end

                ARB_DONE: begin
                    // Requests are ignored here: the winner still holds its
                    // old request during this cycle.
                    state     <= ARB_IDLE;
                    kill_pend <= 1'b0;
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign in_done = (state == ARB_DONE);

    // A kill arriving in DONE itself suppresses the pulse without waiting
    // for kill_pend; the memory access has completed either way.
    assign bus.if_valid = in_done && (owner == GNT_FETCH) && !kill_pend && !bus.if_kill;
    assign bus.d_valid  = in_done && (owner == GNT_DATA);

    // Read data only carries meaning in DONE; it is forced to zero elsewhere
    // so the outputs are quiet while idle or in reset.
    assign bus.if_rdata = (in_done && (owner == GNT_FETCH)) ? bus.mem_rdata : '0;
    assign bus.d_rdata  = (in_done && (owner == GNT_DATA))  ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b2 ();
    mem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) b1 ();

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(2)) u2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    mem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) u1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    // memory model: preloaded words, writes captured on the strobe, reads
    // returned after MEM_LATENCY cycles through a register pipeline
    logic [31:0] mem [logic [31:0]];
    logic [31:0] p2a = '0, p2b = '0, p1a = '0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'hFFFF_FFFF;
    endfunction

    always @(posedge clk) begin
        p2a <= b2.mem_en ? rd(b2.mem_addr) : 32'h0;
        p2b <= p2a;
        p1a <= b1.mem_en ? rd(b1.mem_addr) : 32'h0;
        if (b2.mem_en && b2.mem_we) mem[b2.mem_addr] = b2.mem_wdata;
    end
    assign b2.mem_rdata = p2b;
    assign b1.mem_rdata = p1a;

    // scoreboard
    typedef struct {
        int          u;
        int          cyc;
        logic [31:0] a;
        logic        we;
        logic [31:0] d;
        bit          dc;
    } ev_t;

    ev_t q_mem[$];
    ev_t q_if[$];
    ev_t q_d[$];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_mem(input int u, input int c, input logic [31:0] a,
                           input logic we, input logic [31:0] d);
        ev_t e;
        e.u = u; e.cyc = c; e.a = a; e.we = we; e.d = d; e.dc = we;
        q_mem.push_back(e);
    endtask

    // s: 1 = fetch valid, 2 = data valid; dc selects whether rdata is checked
    task automatic exp_val(input int s, input int u, input int c,
                           input logic [31:0] d, input bit dc);
        ev_t e;
        e.u = u; e.cyc = c; e.a = '0; e.we = 1'b0; e.d = d; e.dc = dc;
        if (s == 1) q_if.push_back(e);
        else        q_d.push_back(e);
    endtask

    // s: 0 = mem_en strobe, 1 = if_valid, 2 = d_valid
    task automatic obs(input int s, input int u, input logic [31:0] a,
                       input logic we, input logic [31:0] d);
        ev_t   e;
        int    n;
        string nm;
        nm = $sformatf("u%0d_%s", u, (s == 0) ? "mem_en" : (s == 1) ? "if_valid" : "d_valid");
        n  = (s == 0) ? q_mem.size() : (s == 1) ? q_if.size() : q_d.size();
        if (n == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_unexpected: got a pulse at cycle %0d, required none", nm, cyc);
            return;
        end
        case (s)
            0:       e = q_mem.pop_front();
            1:       e = q_if.pop_front();
            default: e = q_d.pop_front();
        endcase
        chk({nm, "_unit"}, u, e.u);
        chk({nm, "_cycle"}, cyc, e.cyc);
        if (s == 0) begin
            chk({nm, "_addr"}, a, e.a);
            chk({nm, "_we"}, {31'b0, we}, {31'b0, e.we});
            if (e.dc) chk({nm, "_wdata"}, d, e.d);
        end else if (e.dc) begin
            chk({nm, "_rdata"}, d, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (b2.mem_en) obs(0, 2, b2.mem_addr, b2.mem_we, b2.mem_wdata);
            else           chk("u2_mem_we_idle", {31'b0, b2.mem_we}, 32'h0);
            if (b2.if_valid) obs(1, 2, 32'h0, 1'b0, b2.if_rdata);
            if (b2.d_valid)  obs(2, 2, 32'h0, 1'b0, b2.d_rdata);
            if (b1.mem_en) obs(0, 1, b1.mem_addr, b1.mem_we, b1.mem_wdata);
            else           chk("u1_mem_we_idle", {31'b0, b1.mem_we}, 32'h0);
            if (b1.if_valid) obs(1, 1, 32'h0, 1'b0, b1.if_rdata);
            if (b1.d_valid)  obs(2, 1, 32'h0, 1'b0, b1.d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_en"},    {31'b0, b2.mem_en},   32'h0);
        chk({tag, "_mem_we"},    {31'b0, b2.mem_we},   32'h0);
        chk({tag, "_mem_addr"},  b2.mem_addr,          32'h0);
        chk({tag, "_mem_wdata"}, b2.mem_wdata,         32'h0);
        chk({tag, "_if_valid"},  {31'b0, b2.if_valid}, 32'h0);
        chk({tag, "_d_valid"},   {31'b0, b2.d_valid},  32'h0);
        chk({tag, "_if_rdata"},  b2.if_rdata,          32'h0);
        chk({tag, "_d_rdata"},   b2.d_rdata,           32'h0);
    endtask

    // fetch 0x10 at N then 0x14 back-to-back
    task automatic two_fetches();
        int n;
        n = cyc;
        b2.if_req = 1'b1; b2.if_addr = 32'h10;
        exp_mem(2, n + 1, 32'h10, 1'b0, 32'h0);
        exp_val(1, 2, n + 3, 32'hDEAD_BEEF, 1'b1);
        exp_mem(2, n + 5, 32'h14, 1'b0, 32'h0);
        exp_val(1, 2, n + 7, 32'h0123_4567, 1'b1);
        repeat (4) tick();
        b2.if_addr = 32'h14;
        repeat (4) tick();
        b2.if_req = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        b2.if_req = 0; b2.if_addr = 0; b2.if_kill = 0;
        b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;
        b1.if_req = 0; b1.if_addr = 0; b1.if_kill = 0;
        b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        mem[32'h10]  = 32'hDEAD_BEEF;
        mem[32'h14]  = 32'h0123_4567;
        mem[32'h20]  = 32'h1111_2222;
        mem[32'h24]  = 32'h3333_4444;
        mem[32'h40]  = 32'h4040_4040;
        mem[32'h200] = 32'hCAFE_F00D;
        mem[32'h204] = 32'h0BAD_CAFE;

        repeat (2) tick();
        chk_quiet("reset");
        rst = 1'b1;
        repeat (2) tick();

        // single fetch and back-to-back fetch
        two_fetches();

        // contention: data first, then fetch, alternating
        n = cyc;
        b2.if_req = 1'b1; b2.if_addr = 32'h20;
        b2.d_req  = 1'b1; b2.d_we = 1'b0; b2.d_addr = 32'h200;
        exp_mem(2, n + 1,  32'h200, 1'b0, 32'h0);
        exp_val(2, 2, n + 3,  32'hCAFE_F00D, 1'b1);
        exp_mem(2, n + 5,  32'h20, 1'b0, 32'h0);
        exp_val(1, 2, n + 7,  32'h1111_2222, 1'b1);
        exp_mem(2, n + 9,  32'h204, 1'b0, 32'h0);
        exp_val(2, 2, n + 11, 32'h0BAD_CAFE, 1'b1);
        exp_mem(2, n + 13, 32'h24, 1'b0, 32'h0);
        exp_val(1, 2, n + 15, 32'h3333_4444, 1'b1);
        repeat (4) tick();
        b2.d_addr = 32'h204;
        repeat (4) tick();
        b2.if_addr = 32'h24;
        repeat (4) tick();
        b2.d_req = 1'b0;
        repeat (4) tick();
        b2.if_req = 1'b0;
        tick();

        // write 0x5A to 0x100, then read it back
        n = cyc;
        b2.d_req = 1'b1; b2.d_we = 1'b1; b2.d_addr = 32'h100; b2.d_wdata = 32'h5A;
        exp_mem(2, n + 1, 32'h100, 1'b1, 32'h5A);
        exp_val(2, 2, n + 3, 32'h0, 1'b0);
        exp_mem(2, n + 5, 32'h100, 1'b0, 32'h0);
        exp_val(2, 2, n + 7, 32'h5A, 1'b1);
        repeat (4) tick();
        b2.d_we = 1'b0;
        repeat (4) tick();
        b2.d_req = 1'b0;
        tick();

        // fetch killed in WAIT, redirected fetch accepted right after DONE
        n = cyc;
        b2.if_req = 1'b1; b2.if_addr = 32'h30;
        exp_mem(2, n + 1, 32'h30, 1'b0, 32'h0);
        exp_mem(2, n + 5, 32'h40, 1'b0, 32'h0);
        exp_val(1, 2, n + 7, 32'h4040_4040, 1'b1);
        repeat (2) tick();
        b2.if_kill = 1'b1;
        tick();
        b2.if_kill = 1'b0;
        b2.if_addr = 32'h40;
        repeat (5) tick();
        b2.if_req = 1'b0;
        tick();

        // fetch killed in DONE itself
        n = cyc;
        b2.if_req = 1'b1; b2.if_addr = 32'h50;
        exp_mem(2, n + 1, 32'h50, 1'b0, 32'h0);
        repeat (3) tick();
        b2.if_kill = 1'b1;
        tick();
        b2.if_kill = 1'b0;
        b2.if_req  = 1'b0;
        tick();

        // kill during a data access has no effect
        n = cyc;
        b2.d_req = 1'b1; b2.d_addr = 32'h200;
        exp_mem(2, n + 1, 32'h200, 1'b0, 32'h0);
        exp_val(2, 2, n + 3, 32'hCAFE_F00D, 1'b1);
        repeat (2) tick();
        b2.if_kill = 1'b1;
        repeat (2) tick();
        b2.if_kill = 1'b0;
        b2.d_req   = 1'b0;
        tick();

        // asynchronous reset in WAIT abandons the fetch
        n = cyc;
        b2.if_req = 1'b1; b2.if_addr = 32'h10;
        exp_mem(2, n + 1, 32'h10, 1'b0, 32'h0);
        repeat (2) tick();
        #1 rst = 1'b0;
        #1 chk_quiet("async_rst");
        b2.if_req = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        two_fetches();

        // MEM_LATENCY=1 build: data read then fetch, period 3
        n = cyc;
        b1.d_req = 1'b1; b1.d_we = 1'b0; b1.d_addr = 32'h10;
        exp_mem(1, n + 1, 32'h10, 1'b0, 32'h0);
        exp_val(2, 1, n + 2, 32'hDEAD_BEEF, 1'b1);
        exp_mem(1, n + 4, 32'h14, 1'b0, 32'h0);
        exp_val(1, 1, n + 5, 32'h0123_4567, 1'b1);
        repeat (3) tick();
        b1.d_req = 1'b0;
        b1.if_req = 1'b1; b1.if_addr = 32'h14;
        repeat (3) tick();
        b1.if_req = 1'b0;
        repeat (3) tick();

        chk("left_mem_en",   q_mem.size(), 32'h0);
        chk("left_if_valid", q_if.size(),  32'h0);
        chk("left_d_valid",  q_d.size(),   32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
